// File: rtl/serial_sub_nbit.sv
// serial_sub_nbit: bit-serial N-bit subtractor, d = a - b - bin.
// One full-subtractor cell processes one bit per clock, LSB first; the
// borrow between bits lives in a register. Valid/ready handshake on the
// operand side and on the result side.
module serial_sub_nbit #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         ovf,
    output logic         busy
);

    // Bit counter only has to reach N-1, so ceil(log2 N) bits suffice.
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e          state_q;
    logic [N-1:0]    a_sh_q;
    logic [N-1:0]    b_sh_q;
    logic [N-1:0]    d_sh_q;
    logic            brw_q;
    logic [CntW-1:0] cnt_q;
    logic            sa_q;
    logic            sb_q;
    logic            bout_q;
    logic            ovf_q;

    logic            cell_a;
    logic            cell_b;
    logic            cell_d;
    logic            cell_bo;
    logic            last_bit;

    // Full-subtractor cell on the current LSBs and the stored borrow.
    always_comb begin
        cell_a   = a_sh_q[0];
        cell_b   = b_sh_q[0];
        cell_d   = cell_a ^ cell_b ^ brw_q;
        cell_bo  = (~cell_a & cell_b) | ((~cell_a | cell_b) & brw_q);
        last_bit = (cnt_q == CntLast);
    end

    // Control FSM and serial datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            d_sh_q  <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        brw_q   <= bin;
                        cnt_q   <= '0;
                        sa_q    <= a[N-1];
                        sb_q    <= b[N-1];
                        d_sh_q  <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    d_sh_q <= {cell_d, d_sh_q[N-1:1]};
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    brw_q  <= cell_bo;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_bit) begin
                        // cell_d here is the sign bit of the difference.
                        bout_q  <= cell_bo;
                        ovf_q   <= (sa_q ^ sb_q) & (sa_q ^ cell_d);
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    // New operands are never taken on the release edge.
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Status and result outputs decode straight from registers.
    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q == StRun);
        out_valid = (state_q == StDone);
        d         = d_sh_q;
        bout      = bout_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_serial_sub_nbit.sv
// Testbench for serial_sub_nbit with N = 8: directed vectors plus a
// streaming run against an arithmetic reference.
module tb_serial_sub_nbit;

    localparam int unsigned N = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] d;
    logic         bout;
    logic         ovf;
    logic         busy;

    int errors = 0;
    int checks = 0;

    serial_sub_nbit #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: 9-bit difference gives result and unsigned borrow.
    function automatic logic [9:0] ref_sub(input logic [7:0] x, input logic [7:0] y,
                                           input logic bi);
        logic [8:0] diff;
        logic       v;
        diff = {1'b0, x} - {1'b0, y} - {8'd0, bi};
        v    = (x[7] != y[7]) && (diff[7] != x[7]);
        return {v, diff};
    endfunction

    // Present operands and complete the input handshake; ok=0 on timeout.
    task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                        output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (!in_ready && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) ok = 1'b0;
        a        = av;
        b        = bv;
        bin      = bi;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid; ok=0 on timeout.
    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = out_valid;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_d: got %h want 00", d); end
        checks++; if (bout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_flags: got bout=%b ovf=%b want 0 0", bout, ovf); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [7:0] va [5];
        logic [7:0] vb [5];
        logic       vi [5];
        logic [7:0] ed [5];
        logic       eb [5];
        logic       eo [5];
        bit         ok;
        int         lat;
        va = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F};
        vb = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF};
        vi = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
        ed = '{8'h02, 8'hFE, 8'hFF, 8'h7F, 8'h80};
        eb = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
        eo = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
        for (int i = 0; i < 5; i++) begin
            send(va[i], vb[i], vi[i], ok);
            checks++; if (!ok) begin errors++; $display("FAIL vec%0d_accept: in_ready never high", i); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL vec%0d_busy: got %b want 1", i, busy); end
            wait_done(lat, ok);
            checks++; if (!ok || lat != N) begin errors++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, N); end
            checks++; if (d !== ed[i]) begin errors++; $display("FAIL vec%0d_d: got %h want %h", i, d, ed[i]); end
            checks++; if (bout !== eb[i]) begin errors++; $display("FAIL vec%0d_bout: got %b want %b", i, bout, eb[i]); end
            checks++; if (ovf !== eo[i]) begin errors++; $display("FAIL vec%0d_ovf: got %b want %b", i, ovf, eo[i]); end
            release_result();
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_release: got in_ready=%b out_valid=%b want 1 0", i, in_ready, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        send(8'hA5, 8'h5A, 1'b0, ok);
        wait_done(lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_done: out_valid got 0 want 1"); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (d !== 8'h4B || bout !== 1'b0 || ovf !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: got d=%h bout=%b ovf=%b want 4b 0 1", i, d, bout, ovf); end
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hs%0d: got in_ready=%b out_valid=%b want 0 1", i, in_ready, out_valid); end
            a        = 8'h33;
            b        = 8'h11;
            in_valid = (i == 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || busy !== 1'b0 || d !== 8'h4B) begin errors++; $display("FAIL bp_after_pulse: got out_valid=%b busy=%b d=%h want 1 0 4b", out_valid, busy, d); end
        release_result();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: got in_ready=%b busy=%b want 1 0", in_ready, busy); end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int lat;
        send(8'hFF, 8'h00, 1'b0, ok);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_run_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_run_state: got out_valid=%b busy=%b want 0 0", out_valid, busy); end
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_run_d: got %h want 00", d); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_run_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(8'h10, 8'h01, 1'b0, ok);
        wait_done(lat, ok);
        checks++; if (!ok || lat != N) begin errors++; $display("FAIL rst_after_latency: got %0d want %0d", lat, N); end
        checks++; if (d !== 8'h0F || bout !== 1'b0) begin errors++; $display("FAIL rst_after_result: got d=%h bout=%b want 0f 0", d, bout); end
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_q[$];
        logic [9:0] e;
        int         last_acc;
        int         n_out;
        bit         accepted;
        last_acc  = -1;
        n_out     = 0;
        accepted  = 1'b0;
        a         = 8'($urandom);
        b         = 8'($urandom);
        bin       = 1'($urandom);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 72; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (last_acc >= 0) begin
                    checks++; if (c - last_acc != N + 2) begin errors++; $display("FAIL b2b_interval: got %0d want %0d", c - last_acc, N + 2); end
                end
                last_acc = c;
                exp_q.push_back(ref_sub(a, b, bin));
                accepted = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b2b_unexpected: got result d=%h want none", d);
                end else begin
                    e = exp_q.pop_front();
                    n_out++;
                    checks++; if (d !== e[7:0] || bout !== e[8] || ovf !== e[9]) begin errors++; $display("FAIL b2b_result%0d: got d=%h bout=%b ovf=%b want %h %b %b", n_out, d, bout, ovf, e[7:0], e[8], e[9]); end
                end
            end
            @(posedge clk); #1;
            if (accepted) begin
                a   = 8'($urandom);
                b   = 8'($urandom);
                bin = 1'($urandom);
            end
            accepted = 1'b0;
        end
        in_valid = 1'b0;
        checks++; if (n_out < 6) begin errors++; $display("FAIL b2b_count: got %0d results want at least 6", n_out); end
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: got in_ready=%b want 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
